usb_rx_deserializer: RTL

Receive-side front end of the USB transceiver. Samples the differential line pair (DP_i/DM_i), recovers bit timing, NRZI-decodes, detects SYNC, removes stuffed bits, assembles LSB-first bytes and detects EOP. It sits directly upstream of the packet/PID decoder, which consumes the byte stream on data_out/data_valid.

---
 rtl/usb_pkg.sv | 15 +
 rtl/usb_rx_dpll.sv | 31 +++
 rtl/usb_rx_deserializer.sv | 91 +++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: line-state encoding, rx FSM states and protocol constants shared by the USB receive path.
package usb_pkg;
    typedef logic [1:0] line_t;
    // {D+, D-}
    localparam line_t LS_SE0 = 2'b00;
    localparam line_t LS_K   = 2'b01;
    localparam line_t LS_J   = 2'b10;
    localparam line_t LS_SE1 = 2'b11;
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_SYNC = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_EOP  = 2'd3;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] MAX_ONES = 3'd6;
endpackage

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: registers the line pair and strobes a mid-bit sample, re-phasing on every line transition.
module usb_rx_dpll
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  dp,
    input  logic  dm,
    output logic  sample_en,
    output line_t line
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    line_t line_q, line_d;
    logic [PW-1:0] phase, phase_eff;
    assign phase_eff = (line_q != line_d) ? '0 : phase;
    assign sample_en = phase_eff == PW'(CLKS_PER_BIT / 2 - 1);
    assign line = line_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= LS_J;
            line_d <= LS_J;
            phase  <= '0;
        end else begin
            line_q <= {dp, dm};
            line_d <= line_q;
            phase  <= (phase_eff == PW'(CLKS_PER_BIT - 1)) ? '0 : phase_eff + 1'b1;
        end
    end
endmodule

// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: NRZI decode, SYNC hunt, bit-unstuffing, LSB-first byte assembly and EOP detection.
module usb_rx_deserializer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2,
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       DP_i,
    input  logic       DM_i,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       rx_active,
    output logic       pkt_end,
    output logic       stuff_err,
    output logic       align_err
);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    logic          sample_en, armed, se0_2, misaligned, dec;
    line_t         ls_raw, ls, prev;
    logic [1:0]    state;
    logic [7:0]    shreg, nxt;
    logic [2:0]    bit_cnt, ones;
    logic [TW-1:0] sync_cnt;
    usb_rx_dpll #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dpll (
        .clk(clk), .rst(rst), .dp(DP_i), .dm(DM_i), .sample_en(sample_en), .line(ls_raw)
    );
    // SE1 is only a fault once a packet is underway; before that it reads as idle J
    assign ls  = (ls_raw == LS_SE1 && (state == RX_IDLE || state == RX_SYNC)) ? LS_J : ls_raw;
    assign dec = ls == prev;
    assign nxt = {dec, shreg[7:1]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE; prev <= LS_J; shreg <= '0; bit_cnt <= '0; ones <= '0; sync_cnt <= '0;
            armed <= 1'b0; se0_2 <= 1'b0; misaligned <= 1'b0;
            data_out <= '0; data_valid <= 1'b0; rx_active <= 1'b0;
            pkt_end <= 1'b0; stuff_err <= 1'b0; align_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            pkt_end    <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            if (sample_en) begin
                case (state)
                    RX_IDLE: begin
                        if (ls == LS_J) armed <= 1'b1;
                        // preload ones so only a complete 8-bit SYNC can match
                        if (ls == LS_K && armed) begin
                            state <= RX_SYNC; prev <= LS_K; shreg <= 8'h7F; sync_cnt <= TW'(1); armed <= 1'b0;
                        end
                    end
                    RX_SYNC: begin
                        prev <= ls; shreg <= nxt; sync_cnt <= sync_cnt + 1'b1;
                        if (ls == LS_SE0 || (nxt != SYNC_PATTERN && sync_cnt == TW'(SYNC_TIMEOUT - 1)))
                            state <= RX_IDLE;
                        else if (nxt == SYNC_PATTERN) begin
                            state <= RX_DATA; rx_active <= 1'b1; ones <= 3'd1; bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (ls == LS_SE0) begin
                            state <= RX_EOP; se0_2 <= 1'b0; misaligned <= bit_cnt != 3'd0;
                        end else if (ls == LS_SE1 || (ones == MAX_ONES && dec)) begin
                            state <= RX_IDLE; rx_active <= 1'b0; pkt_end <= 1'b1; stuff_err <= 1'b1; armed <= 1'b0;
                        end else begin
                            prev <= ls;
                            if (ones == MAX_ONES) ones <= 3'd0;
                            else begin
                                ones <= dec ? ones + 1'b1 : 3'd0;
                                shreg <= nxt;
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == 3'd7) begin
                                    data_out <= nxt; data_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    RX_EOP: begin
                        if (ls == LS_SE0) se0_2 <= 1'b1;
                        else if (ls != LS_K && se0_2) begin
                            state <= RX_IDLE; rx_active <= 1'b0; pkt_end <= 1'b1; align_err <= misaligned; armed <= 1'b1;
                        end else begin
                            state <= RX_IDLE; rx_active <= 1'b0; pkt_end <= 1'b1; armed <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule
